// File: rtl/aes_pkg.sv
// AES helpers shared by the key-schedule blocks:
// S-box, RCON, RotWord and scheduler state encoding.
package aes_pkg;

  localparam int NK = 4;
  localparam int NR = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    EMIT = 2'd2
  } state_e;

  localparam logic [0:255][7:0] SBOX_TBL = {
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TBL[x];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] v;
    case (r)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

endpackage

// File: rtl/aes_sub_word.sv
// Bytewise AES S-box substitution of one 32-bit word.
// Shared by the forward and inverse key schedules.
module aes_sub_word
  import aes_pkg::*;
(
  input  logic [31:0] word_i,
  output logic [31:0] word_o
);

  assign word_o = {
    sbox(word_i[31:24]),
    sbox(word_i[23:16]),
    sbox(word_i[15:8]),
    sbox(word_i[7:0])
  };

endmodule

// File: rtl/aes_inv_key_scheduler.sv
// On-demand AES-128 round-key source for decryption:
// derives the round-10 key, then walks keys back to round 0.
module aes_inv_key_scheduler
  import aes_pkg::*;
#(
  parameter int NK = aes_pkg::NK,
  parameter int NR = aes_pkg::NR
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [32*NK-1:0]  key_in,
  input  logic              key_is_last,
  output logic [32*NK-1:0]  round_key,
  output logic [3:0]        round_idx,
  output logic              key_valid,
  input  logic              key_ready,
  output logic              key_last,
  output logic              busy
);

  localparam logic [3:0] LAST_IDX = 4'(NR);

  state_e             state_q;
  logic [32*NK-1:0]   key_q;
  logic [3:0]         idx_q;
  logic               valid_q;
  logic               last_q;
  logic               busy_q;

  logic [31:0]        w0, w1, w2, w3;
  logic [31:0]        sw_in, sw_out;
  logic [127:0]       fwd_key_d, inv_key_d;
  logic [3:0]         idx_inc_d;
  logic [31:0]        f0, f1, f2, i0, i1, i2, i3;
  logic               hs;

  assign {w0, w1, w2, w3} = key_q;
  assign idx_inc_d = idx_q + 4'd1;
  assign hs        = valid_q & key_ready;

  // One S-box bank: w3 going forward, rebuilt w3' going back.
  assign i3    = w3 ^ w2;
  assign sw_in = (state_q == EMIT) ? rot_word(i3) : rot_word(w3);

  aes_sub_word u_sub_word (
    .word_i (sw_in),
    .word_o (sw_out)
  );

  assign f0 = w0 ^ sw_out ^ {rcon(idx_inc_d), 24'h0};
  assign f1 = w1 ^ f0;
  assign f2 = w2 ^ f1;
  assign fwd_key_d = {f0, f1, f2, w3 ^ f2};

  assign i2 = w2 ^ w1;
  assign i1 = w1 ^ w0;
  assign i0 = w0 ^ sw_out ^ {rcon(idx_q), 24'h0};
  assign inv_key_d = {i0, i1, i2, i3};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      key_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            key_q  <= key_in;
            busy_q <= 1'b1;
            last_q <= 1'b0;
            if (key_is_last) begin
              idx_q   <= LAST_IDX;
              valid_q <= 1'b1;
              state_q <= EMIT;
            end else begin
              idx_q   <= 4'd0;
              state_q <= FWD;
            end
          end
        end
        FWD: begin
          key_q <= fwd_key_d;
          idx_q <= idx_inc_d;
          if (idx_inc_d == LAST_IDX) begin
            valid_q <= 1'b1;
            state_q <= EMIT;
          end
        end
        EMIT: begin
          if (hs) begin
            if (idx_q == 4'd0) begin
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              busy_q  <= 1'b0;
              state_q <= IDLE;
            end else begin
              key_q  <= inv_key_d;
              idx_q  <= idx_q - 4'd1;
              last_q <= (idx_q == 4'd1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign round_key = key_q;
  assign round_idx = idx_q;
  assign key_valid = valid_q;
  assign key_last  = last_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_aes_inv_key_scheduler.sv
// Directed bench for the inverse AES-128 key scheduler
// using FIPS-197 round-key vectors.
module tb_aes_inv_key_scheduler;

  localparam logic [127:0] FIPS_K   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] FIPS_R9  = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] FIPS_R8  = 128'head27321b58dbad2312bf5607f8d292f;
  localparam logic [127:0] FIPS_R5  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
  localparam logic [127:0] FIPS_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] SEQ_K    = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] SEQ_R10  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [127:0] key_in;
  logic         key_is_last;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         key_valid;
  logic         key_ready;
  logic         key_last;
  logic         busy;

  int errors = 0;
  int checks = 0;

  logic [127:0] got_key  [0:10];
  logic [3:0]   got_idx  [0:10];
  logic         got_last [0:10];
  int lat, hs, cyc, stab_err;

  aes_inv_key_scheduler dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .key_in      (key_in),
    .key_is_last (key_is_last),
    .round_key   (round_key),
    .round_idx   (round_idx),
    .key_valid   (key_valid),
    .key_ready   (key_ready),
    .key_last    (key_last),
    .busy        (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic collect(input logic [127:0] k, input logic l,
                         input bit rnd);
    logic [127:0] pk;
    logic [3:0]   pi;
    logic         pl;
    bit           r;
    key_in = k;
    key_is_last = l;
    key_ready = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    key_is_last = 1'b0;
    lat = 0;
    while (!key_valid && lat < 40) begin
      step();
      lat++;
    end
    hs = 0;
    cyc = 0;
    stab_err = 0;
    while (key_valid && hs < 11 && cyc < 300) begin
      r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      key_ready = r;
      pk = round_key;
      pi = round_idx;
      pl = key_last;
      step();
      cyc++;
      if (r) begin
        got_key[hs]  = pk;
        got_idx[hs]  = pi;
        got_last[hs] = pl;
        hs++;
      end else if (round_key !== pk || round_idx !== pi
                   || key_valid !== 1'b1) begin
        stab_err++;
      end
    end
    key_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0;
    key_in = '0;
    key_is_last = 1'b0;
    key_ready = 1'b0;
    #12;
    checks++;
    if (round_key !== 128'h0) begin
      $display("FAIL reset_key: got %h want 0", round_key);
      errors++;
    end
    checks++;
    if (round_idx !== 4'd0) begin
      $display("FAIL reset_idx: got %0d want 0", round_idx);
      errors++;
    end
    checks++;
    if ({key_valid, key_last, busy} !== 3'b000) begin
      $display("FAIL reset_flags: got %b want 000",
               {key_valid, key_last, busy});
      errors++;
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (busy !== 1'b0 || key_valid !== 1'b0) begin
      $display("FAIL idle_after_reset: busy %b valid %b want 0 0",
               busy, key_valid);
      errors++;
    end
  endtask

  task automatic test_fips_key;
    collect(FIPS_K, 1'b0, 1'b0);
    checks++;
    if (lat !== 10) begin
      $display("FAIL fips_latency: got %0d want 10", lat);
      errors++;
    end
    checks++;
    if (got_key[0] !== FIPS_R10 || got_idx[0] !== 4'd10) begin
      $display("FAIL fips_r10: got %h/%0d want %h/10",
               got_key[0], got_idx[0], FIPS_R10);
      errors++;
    end
    checks++;
    if (got_key[1] !== FIPS_R9 || got_idx[1] !== 4'd9) begin
      $display("FAIL fips_r9: got %h/%0d want %h/9",
               got_key[1], got_idx[1], FIPS_R9);
      errors++;
    end
    checks++;
    if (got_key[2] !== FIPS_R8) begin
      $display("FAIL fips_r8: got %h want %h", got_key[2], FIPS_R8);
      errors++;
    end
    checks++;
    if (got_key[10] !== FIPS_K || got_idx[10] !== 4'd0) begin
      $display("FAIL fips_r0: got %h/%0d want %h/0",
               got_key[10], got_idx[10], FIPS_K);
      errors++;
    end
    checks++;
    if (got_last[10] !== 1'b1 || got_last[0] !== 1'b0) begin
      $display("FAIL fips_last_flag: got %b%b want 10",
               got_last[10], got_last[0]);
      errors++;
    end
    checks++;
    if (hs !== 11 || cyc !== 11) begin
      $display("FAIL fips_throughput: got %0d keys in %0d cycles want 11/11",
               hs, cyc);
      errors++;
    end
    checks++;
    if (key_valid !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL fips_idle: valid %b busy %b want 0 0",
               key_valid, busy);
      errors++;
    end
  endtask

  task automatic test_seq_key;
    collect(SEQ_K, 1'b0, 1'b0);
    checks++;
    if (got_key[0] !== SEQ_R10) begin
      $display("FAIL seq_r10: got %h want %h", got_key[0], SEQ_R10);
      errors++;
    end
    checks++;
    if (got_key[10] !== SEQ_K) begin
      $display("FAIL seq_r0: got %h want %h", got_key[10], SEQ_K);
      errors++;
    end
  endtask

  task automatic test_key_is_last;
    collect(FIPS_R10, 1'b1, 1'b0);
    checks++;
    if (lat !== 0) begin
      $display("FAIL last_latency: got %0d want 0", lat);
      errors++;
    end
    checks++;
    if (got_key[0] !== FIPS_R10 || got_idx[0] !== 4'd10) begin
      $display("FAIL last_first: got %h/%0d want %h/10",
               got_key[0], got_idx[0], FIPS_R10);
      errors++;
    end
    checks++;
    if (got_key[9] !== FIPS_R1) begin
      $display("FAIL last_r1: got %h want %h", got_key[9], FIPS_R1);
      errors++;
    end
    checks++;
    if (got_key[10] !== FIPS_K) begin
      $display("FAIL last_r0: got %h want %h", got_key[10], FIPS_K);
      errors++;
    end
  endtask

  task automatic test_random_ready;
    collect(128'h0, 1'b0, 1'b1);
    checks++;
    if (got_key[0] !== ZERO_R10) begin
      $display("FAIL zero_r10: got %h want %h", got_key[0], ZERO_R10);
      errors++;
    end
    checks++;
    if (stab_err !== 0) begin
      $display("FAIL zero_stable: got %0d unstable stalls want 0",
               stab_err);
      errors++;
    end
    checks++;
    if (hs !== 11 || key_valid !== 1'b0) begin
      $display("FAIL zero_count: got %0d handshakes valid %b want 11 0",
               hs, key_valid);
      errors++;
    end
    checks++;
    if (got_key[10] !== 128'h0 || got_last[10] !== 1'b1) begin
      $display("FAIL zero_r0: got %h last %b want 0 last 1",
               got_key[10], got_last[10]);
      errors++;
    end
  endtask

  task automatic test_ignore_start;
    int n;
    key_in = FIPS_K;
    key_is_last = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    key_in = 128'h0;
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (round_idx !== 4'd4 || busy !== 1'b1) begin
      $display("FAIL ign_fwd_idx: got %0d busy %b want 4 1",
               round_idx, busy);
      errors++;
    end
    n = 0;
    while (!key_valid && n < 40) begin
      step();
      n++;
    end
    checks++;
    if (round_key !== FIPS_R10 || round_idx !== 4'd10) begin
      $display("FAIL ign_fwd_key: got %h/%0d want %h/10",
               round_key, round_idx, FIPS_R10);
      errors++;
    end
    key_in = ZERO_R10;
    key_is_last = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    key_is_last = 1'b0;
    checks++;
    if (round_key !== FIPS_R10 || round_idx !== 4'd10) begin
      $display("FAIL ign_emit_key: got %h/%0d want %h/10",
               round_key, round_idx, FIPS_R10);
      errors++;
    end
    key_ready = 1'b1;
    n = 0;
    while (key_valid && round_idx != 4'd0 && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (round_key !== FIPS_K || key_last !== 1'b1) begin
      $display("FAIL ign_final: got %h last %b want %h last 1",
               round_key, key_last, FIPS_K);
      errors++;
    end
    key_in = ZERO_R10;
    key_is_last = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    key_is_last = 1'b0;
    key_ready = 1'b0;
    checks++;
    if (key_valid !== 1'b0 || busy !== 1'b0 || round_key !== FIPS_K) begin
      $display("FAIL ign_same_edge: valid %b busy %b key %h want 0 0 %h",
               key_valid, busy, round_key, FIPS_K);
      errors++;
    end
    step();
    checks++;
    if (busy !== 1'b0) begin
      $display("FAIL ign_stay_idle: busy %b want 0", busy);
      errors++;
    end
  endtask

  task automatic test_reset_mid;
    int n;
    key_in = FIPS_K;
    key_is_last = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (!key_valid && n < 40) begin
      step();
      n++;
    end
    key_ready = 1'b1;
    n = 0;
    while (round_idx != 4'd5 && n < 20) begin
      step();
      n++;
    end
    key_ready = 1'b0;
    checks++;
    if (round_key !== FIPS_R5 || round_idx !== 4'd5) begin
      $display("FAIL mid_r5: got %h/%0d want %h/5",
               round_key, round_idx, FIPS_R5);
      errors++;
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (round_key !== 128'h0 || round_idx !== 4'd0
        || {key_valid, key_last, busy} !== 3'b000) begin
      $display("FAIL mid_reset: key %h idx %0d flags %b want all 0",
               round_key, round_idx, {key_valid, key_last, busy});
      errors++;
    end
    #1 rst_n = 1'b1;
    collect(SEQ_K, 1'b0, 1'b0);
    checks++;
    if (lat !== 10 || got_key[0] !== SEQ_R10 || got_key[10] !== SEQ_K) begin
      $display("FAIL mid_rerun: lat %0d first %h last %h want 10 %h %h",
               lat, got_key[0], got_key[10], SEQ_R10, SEQ_K);
      errors++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_fips_key();
    test_seq_key();
    test_key_is_last();
    test_random_ready();
    test_ignore_start();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
